// File: rtl/hamming_enc_fifo.sv
// Hamming(7,4) encoder with optional single-bit error injection,
// feeding a small valid/ready FIFO toward the decoder side.
module hamming_enc_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                in_data,
    input  logic                      inj_en,
    input  logic [2:0]                inj_bit,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [6:0]                out_data,
    output logic [$clog2(DEPTH):0]    level,
    output logic [CNT_W-1:0]          sent_cnt,
    output logic [CNT_W-1:0]          inj_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_e;

    state_e          state_q;
    logic [LW-1:0]   level_q, level_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] sent_q, inj_q;

    // Each entry: {flip_flag, codeword[6:0]}
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      head;

    logic [6:0]      code_raw, code_inj, mask;
    logic            flip;
    logic            push, pop;

    always_comb begin
        code_raw = {in_data[3] ^ in_data[1] ^ in_data[0],
                    in_data[3] ^ in_data[2] ^ in_data[1],
                    in_data[2] ^ in_data[1] ^ in_data[0],
                    in_data};
        flip     = inj_en && (inj_bit != 3'd7);
        mask     = 7'd1 << inj_bit;
        code_inj = flip ? (code_raw ^ mask) : code_raw;
    end

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q];

    // Storage is never cleared; the empty state masks stale contents.
    assign out_data  = out_valid ? head[6:0] : 7'd0;
    assign level     = level_q;
    assign sent_cnt  = sent_q;
    assign inj_cnt   = inj_q;

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {flip, code_inj};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sent_q   <= '0;
            inj_q    <= '0;
        end else begin
            level_q <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                sent_q   <= sent_q + CNT_W'(1);
                if (head[7]) begin
                    inj_q <= inj_q + CNT_W'(1);
                end
            end
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_q <= PARTIAL;
                    end
                end
                PARTIAL: begin
                    if (push && !pop && level_q == LW'(DEPTH - 1)) begin
                        state_q <= FULL;
                    end else if (pop && !push && level_q == LW'(1)) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_q <= PARTIAL;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_enc_fifo.sv
// Randomized scenario bench for hamming_enc_fifo against a
// queue-based reference model of the encoder and FIFO.
module tb_hamming_enc_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic             inj_en;
    logic [2:0]       inj_bit;
    logic             out_valid;
    logic             out_ready;
    logic [6:0]       out_data;
    logic [2:0]       level;
    logic [CNT_W-1:0] sent_cnt;
    logic [CNT_W-1:0] inj_cnt;

    int vectors;
    int miscompares;

    logic [7:0]       mq [$];
    logic [CNT_W-1:0] m_sent;
    logic [CNT_W-1:0] m_inj;

    hamming_enc_fifo #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .inj_en   (inj_en),
        .inj_bit  (inj_bit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .level    (level),
        .sent_cnt (sent_cnt),
        .inj_cnt  (inj_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Codeword from parity-check masks over the data nibble
    function automatic logic [6:0] enc(input logic [3:0] d);
        return {^(d & 4'b1011), ^(d & 4'b1110), ^(d & 4'b0111), d};
    endfunction

    function automatic logic [2:0] syndrome(input logic [6:0] c);
        return {^(c & 7'b1001011), ^(c & 7'b0101110), ^(c & 7'b0010111)};
    endfunction

    function automatic logic [6:0] exp_out();
        return (mq.size() > 0) ? mq[0][6:0] : 7'd0;
    endfunction

    // Drive one cycle of inputs, advance a clock, update the model.
    task automatic tick(input bit iv, input logic [3:0] d, input bit ie,
                        input logic [2:0] ib, input bit ordy);
        logic [6:0] c;
        bit         fl;
        bit         do_push;
        bit         do_pop;
        logic [7:0] e;
        in_valid  = iv;
        in_data   = d;
        inj_en    = ie;
        inj_bit   = ib;
        out_ready = ordy;
        fl = ie && (ib != 3'd7);
        c  = enc(d);
        if (fl) c = c ^ (7'd1 << ib);
        do_push = iv && (mq.size() < DEPTH);
        do_pop  = ordy && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (do_pop) begin
            e = mq.pop_front();
            m_sent = m_sent + 1'b1;
            if (e[7]) m_inj = m_inj + 1'b1;
        end
        if (do_push) mq.push_back({fl, c});
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inj_en    = 1'b0;
    endtask

    task automatic model_clear();
        mq.delete();
        m_sent = '0;
        m_inj  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (level !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_level got %0d want 0", level);
        end
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_hs got ov=%b ir=%b want ov=0 ir=1",
                     out_valid, in_ready);
        end
        vectors++;
        if (out_data !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_data got %b want 0000000", out_data);
        end
        vectors++;
        if (sent_cnt !== '0 || inj_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_cnt got sent=%0d inj=%0d want 0 0",
                     sent_cnt, inj_cnt);
        end
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_single();
        tick(1'b1, 4'b1011, 1'b0, 3'd0, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 7'b1001011) begin
            miscompares++;
            $display("FAIL single_data got ov=%b %b want ov=1 1001011",
                     out_valid, out_data);
        end
        vectors++;
        if (syndrome(out_data) !== 3'b000) begin
            miscompares++;
            $display("FAIL single_syndrome got %b want 000",
                     syndrome(out_data));
        end
        tick(1'b0, 4'd0, 1'b0, 3'd0, 1'b1);
        vectors++;
        if (sent_cnt !== 16'd1 || level !== 3'd0) begin
            miscompares++;
            $display("FAIL single_pop got sent=%0d lvl=%0d want 1 0",
                     sent_cnt, level);
        end
    endtask

    task automatic test_exhaustive();
        for (int d = 0; d < 16; d++) begin
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL exh_stall d=%0d got ir=%b want 1", d, in_ready);
            end
            tick(1'b1, 4'(d), 1'b0, 3'd0, 1'b1);
            vectors++;
            if (out_data !== enc(4'(d)) || level > 3'd1) begin
                miscompares++;
                $display("FAIL exh_code d=%0d got %b lvl=%0d want %b lvl<=1",
                         d, out_data, level, enc(4'(d)));
            end
        end
        tick(1'b0, 4'd0, 1'b0, 3'd0, 1'b1);
        vectors++;
        if (sent_cnt !== m_sent || level !== 3'd0) begin
            miscompares++;
            $display("FAIL exh_count got sent=%0d lvl=%0d want %0d 0",
                     sent_cnt, level, m_sent);
        end
    endtask

    task automatic test_injection();
        tick(1'b1, 4'b0000, 1'b1, 3'd5, 1'b0);
        vectors++;
        if (out_data !== 7'b0100000) begin
            miscompares++;
            $display("FAIL inj5_data got %b want 0100000", out_data);
        end
        tick(1'b0, 4'd0, 1'b0, 3'd0, 1'b1);
        vectors++;
        if (inj_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL inj5_cnt got %0d want 1", inj_cnt);
        end
        tick(1'b1, 4'b0000, 1'b1, 3'd7, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 7'b0000000) begin
            miscompares++;
            $display("FAIL inj7_data got ov=%b %b want ov=1 0000000",
                     out_valid, out_data);
        end
        tick(1'b0, 4'd0, 1'b0, 3'd0, 1'b1);
        vectors++;
        if (inj_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL inj7_cnt got %0d want 1", inj_cnt);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH + 2; i++) begin
            vectors++;
            if (in_ready !== 1'(i < DEPTH)) begin
                miscompares++;
                $display("FAIL full_ready i=%0d got %b want %b",
                         i, in_ready, 1'(i < DEPTH));
            end
            tick(1'b1, 4'($urandom), 1'b0, 3'd0, 1'b0);
        end
        vectors++;
        if (level !== 3'(DEPTH) || mq.size() != DEPTH) begin
            miscompares++;
            $display("FAIL full_level got %0d want %0d", level, DEPTH);
        end
        for (int n = 0; n < 2 * DEPTH && mq.size() > 0; n++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exp_out()) begin
                miscompares++;
                $display("FAIL full_order n=%0d got %b want %b",
                         n, out_data, exp_out());
            end
            tick(1'b0, 4'd0, 1'b0, 3'd0, 1'b1);
        end
        vectors++;
        if (level !== 3'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL full_drain got lvl=%0d ov=%b want 0 0",
                     level, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 4'($urandom), 1'b1, 3'($urandom), 1'b0);
        tick(1'b1, 4'($urandom), 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (level !== 3'd2 || out_data !== exp_out()) begin
                miscompares++;
                $display("FAIL b2b i=%0d got lvl=%0d %b want 2 %b",
                         i, level, out_data, exp_out());
            end
            tick(1'b1, 4'($urandom), 1'($urandom), 3'($urandom), 1'b1);
        end
        for (int n = 0; n < 2 * DEPTH && mq.size() > 0; n++) begin
            vectors++;
            if (out_data !== exp_out()) begin
                miscompares++;
                $display("FAIL b2b_drain got %b want %b", out_data, exp_out());
            end
            tick(1'b0, 4'd0, 1'b0, 3'd0, 1'b1);
        end
        vectors++;
        if (inj_cnt !== m_inj || sent_cnt !== m_sent) begin
            miscompares++;
            $display("FAIL b2b_cnt got s=%0d i=%0d want %0d %0d",
                     sent_cnt, inj_cnt, m_sent, m_inj);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            vectors++;
            if (level !== 3'(mq.size()) ||
                out_valid !== 1'(mq.size() > 0) ||
                in_ready !== 1'(mq.size() < DEPTH) ||
                out_data !== exp_out() ||
                sent_cnt !== m_sent || inj_cnt !== m_inj) begin
                miscompares++;
                $display("FAIL rand i=%0d got l=%0d ov=%b ir=%b d=%b s=%0d j=%0d want l=%0d d=%b s=%0d j=%0d",
                         i, level, out_valid, in_ready, out_data, sent_cnt,
                         inj_cnt, mq.size(), exp_out(), m_sent, m_inj);
            end
            tick(1'($urandom), 4'($urandom), 1'($urandom), 3'($urandom),
                 1'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] d;
        for (int i = 0; i < DEPTH && mq.size() < 3; i++) begin
            tick(1'b1, 4'($urandom), 1'b0, 3'd0, 1'b0);
        end
        while (mq.size() > 3) tick(1'b0, 4'd0, 1'b0, 3'd0, 1'b1);
        vectors++;
        if (level !== 3'd3) begin
            miscompares++;
            $display("FAIL rmid_pre got lvl=%0d want 3", level);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || level !== 3'd0 || sent_cnt !== '0) begin
            miscompares++;
            $display("FAIL rmid_async got ov=%b lvl=%0d sent=%0d want 0 0 0",
                     out_valid, level, sent_cnt);
        end
        model_clear();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        d = 4'($urandom);
        tick(1'b1, d, 1'b0, 3'd0, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== enc(d) || level !== 3'd1) begin
            miscompares++;
            $display("FAIL rmid_after got ov=%b %b lvl=%0d want 1 %b 1",
                     out_valid, out_data, level, enc(d));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        in_valid    = 1'b0;
        in_data     = 4'd0;
        inj_en      = 1'b0;
        inj_bit     = 3'd0;
        out_ready   = 1'b0;
        model_clear();
        test_reset();
        test_single();
        test_exhaustive();
        test_injection();
        test_full();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
